// File: rtl/tiny16_intc_if.sv
`default_nettype none
// ============================================================================
// tiny16_intc_if
// I/O bus bundle between the tiny16 core (master) and the interrupt controller.
// Revision: 1.0
// ============================================================================
interface tiny16_intc_if;
    logic [15:0] address;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        nwr;
    logic        mem_valid;
    logic        mem_ready;

    modport master (
        output address, data_out, nwr, mem_valid,
        input  data_in, mem_ready
    );

    modport slave (
        input  address, data_out, nwr, mem_valid,
        output data_in, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/tiny16_intc.sv
`default_nettype none
// ============================================================================
// tiny16_intc
// Priority interrupt controller for the tiny16 core with bus-mapped registers.
// Optional level-sensitive sources: define TINY16_INTC_LEVEL_EN.
// Revision: 1.0
// ============================================================================
module tiny16_intc #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [NUM_IRQ-1:0] irq_i,
    output logic                    interrupt_o,
    input  wire logic               in_interrupt_i,
    tiny16_intc_if.slave            bus
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_REQUEST = 2'd1;
    localparam logic [1:0]  S_ACTIVE  = 2'd2;
    localparam logic [1:0]  S_DONE    = 2'd3;
    localparam logic [15:0] NO_SOURCE = 16'hFFFF;

    logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [15:0]        active_q, active_d;
    logic [1:0]         state_q, state_d;
    logic               inint_q;
    logic               mem_ready_q;
    logic [15:0]        data_in_q, rdata;
    logic [3:0]         w_id;

    wire logic               w_sel  = bus.mem_valid & (bus.address[15:3] == BASE_ADDR[15:3]);
    wire logic [2:0]         w_off  = bus.address[2:0];
    // Side effects only on the first select cycle; mem_ready_q doubles as "select seen".
    wire logic               w_wr   = w_sel & ~mem_ready_q & ~bus.nwr;
    wire logic [NUM_IRQ-1:0] w_wdata = bus.data_out[NUM_IRQ-1:0];
    wire logic               unused_data = ^bus.data_out;

    logic [NUM_IRQ-1:0] w_level;
`ifdef TINY16_INTC_LEVEL_EN
    logic [NUM_IRQ-1:0] level_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            level_q <= '0;
        else if (w_wr && w_off == 3'd4)
            level_q <= w_wdata;
    end
    assign w_level = level_q;
`else
    assign w_level = '0;
`endif

    wire logic [NUM_IRQ-1:0] w_edge     = sync2_q & ~prev_q & ~w_level;
    wire logic [NUM_IRQ-1:0] w_req_vec  = pending_q & enable_q;
    wire logic               w_req      = |w_req_vec;
    wire logic [NUM_IRQ-1:0] w_oh       = w_req_vec & (-w_req_vec);
    wire logic               w_inint_rise = in_interrupt_i & ~inint_q;
    wire logic               w_inint_fall = ~in_interrupt_i & inint_q;
    wire logic               w_accept   = (state_q == S_REQUEST) & w_inint_rise;
    wire logic               w_eoi      = w_wr & (w_off == 3'd3);

    always_comb begin
        w_id = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (w_req_vec[i]) w_id = 4'(i);
    end

    // Clears are applied before sets so a same-cycle edge always survives.
    always_comb begin
        pending_d = pending_q;
        if (w_wr && w_off == 3'd0)
            pending_d = pending_d & ~w_wdata;
        if (w_accept)
            pending_d = pending_d & ~w_oh;
        pending_d = pending_d | w_edge;
        pending_d = (pending_d & ~w_level) | (sync2_q & w_level);
    end

    always_comb begin
        enable_d = enable_q;
        if (w_wr && w_off == 3'd1)
            enable_d = w_wdata;
    end

    always_comb begin
        rdata = '0;
        case (w_off)
            3'd0:    rdata = 16'(pending_q);
            3'd1:    rdata = 16'(enable_q);
            3'd2:    rdata = active_q;
`ifdef TINY16_INTC_LEVEL_EN
            3'd4:    rdata = 16'(level_q);
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            active_q    <= NO_SOURCE;
            inint_q     <= 1'b0;
            mem_ready_q <= 1'b0;
            data_in_q   <= '0;
        end else begin
            sync1_q     <= irq_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            active_q    <= active_d;
            inint_q     <= in_interrupt_i;
            mem_ready_q <= w_sel;
            data_in_q   <= w_sel ? rdata : 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (w_req && !in_interrupt_i) state_d = S_REQUEST;
            S_REQUEST: begin
                if (w_inint_rise)
                    state_d = S_ACTIVE;
                else if (!w_req)
                    state_d = S_IDLE;
            end
            S_ACTIVE:  if (w_eoi || w_inint_fall) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // A late enable clear leaves req low at acceptance: report it as spurious.
    always_comb begin
        interrupt_o = (state_q == S_REQUEST) & w_req & ~in_interrupt_i;
        active_d    = active_q;
        if (w_accept)
            active_d = w_req ? 16'(w_id) : NO_SOURCE;
        else if (state_q == S_DONE)
            active_d = NO_SOURCE;
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.data_in   = data_in_q;

endmodule
`default_nettype wire

// File: tb/tb_tiny16_intc.sv
`default_nettype none
// Testbench for tiny16_intc: directed scenarios plus randomized multi-source
// servicing checked against a priority-order reference model.
module tb_tiny16_intc;
    localparam logic [15:0] BASE = 16'hFF00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq = 8'h00;
    logic       in_interrupt = 1'b0;
    wire logic  interrupt;
    int         checks = 0;
    int         failures = 0;

    tiny16_intc_if bus_if ();

    tiny16_intc #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_i          (irq),
        .interrupt_o    (interrupt),
        .in_interrupt_i (in_interrupt),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [15:0] d);
        bus_if.address = BASE | 16'(off);
        bus_if.nwr = 1'b1;
        bus_if.mem_valid = 1'b1;
        tick();
        d = bus_if.data_in;
        bus_if.mem_valid = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [15:0] d);
        bus_if.address = BASE | 16'(off);
        bus_if.data_out = d;
        bus_if.nwr = 1'b0;
        bus_if.mem_valid = 1'b1;
        tick();
        bus_if.mem_valid = 1'b0;
        bus_if.nwr = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [7:0] m);
        irq = m;
        tick();
        irq = 8'h00;
        repeat (4) tick();
    endtask

    task automatic clean();
        irq = 8'h00;
        in_interrupt = 1'b0;
        repeat (3) tick();
        bus_write(3'd4, 16'h0000);
        bus_write(3'd1, 16'h0000);
        bus_write(3'd0, 16'hFFFF);
        repeat (2) tick();
    endtask

    task automatic handler(input int hold, output logic [15:0] id, output bit ok);
        ok = 1'b0;
        id = 16'hDEAD;
        for (int k = 0; k < 20; k++) begin
            if (interrupt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) return;
        in_interrupt = 1'b1;
        tick();
        bus_read(3'd2, id);
        repeat (hold) tick();
        in_interrupt = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        repeat (3) tick();
        checks++; if (interrupt !== 1'b0 || bus_if.mem_ready !== 1'b0 || bus_if.data_in !== 16'h0) begin
            failures++; $display("FAIL reset_outputs: int=%b rdy=%b din=%h expected 0/0/0000", interrupt, bus_if.mem_ready, bus_if.data_in);
        end
        reset = 1'b0;
        tick();
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_pending: got %h expected 0000", d); end
        bus_read(3'd1, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_enable: got %h expected 0000", d); end
        bus_read(3'd2, d);
        checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL reset_active: got %h expected FFFF", d); end
    endtask

    task automatic test_priority();
        logic [15:0] d;
        bit ok;
        bus_write(3'd1, 16'h0005);
        irq = 8'h04; tick();
        irq = 8'h01; tick();
        irq = 8'h00; repeat (5) tick();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL prio_request: int=%b expected 1", interrupt); end
        in_interrupt = 1'b1;
        tick();
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL prio_drop: int=%b expected 0", interrupt); end
        bus_read(3'd2, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL prio_active0: got %h expected 0000", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0004) begin failures++; $display("FAIL prio_pending: got %h expected 0004", d); end
        in_interrupt = 1'b0;
        repeat (2) tick();
        handler(0, d, ok);
        checks++; if (!ok || d !== 16'h0002) begin failures++; $display("FAIL prio_second: ok=%0d active=%h expected 0002", ok, d); end
        bus_read(3'd2, d);
        checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL prio_after_done: got %h expected FFFF", d); end
        clean();
    endtask

    task automatic test_enable_late();
        logic [15:0] d;
        bit seen = 1'b0;
        pulse(8'h08);
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL en_masked: int=%b expected 0", interrupt); end
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0008) begin failures++; $display("FAIL en_pending: got %h expected 0008", d); end
        bus_if.address = BASE | 16'd1; bus_if.data_out = 16'h0008; bus_if.nwr = 1'b0; bus_if.mem_valid = 1'b1;
        tick();
        bus_if.mem_valid = 1'b0; bus_if.nwr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (interrupt === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL en_request: int=%b expected 1 within 2 cycles", interrupt); end
        clean();
    endtask

    task automatic test_w1c();
        logic [15:0] d;
        bus_write(3'd1, 16'h0002);
        pulse(8'h02);
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL w1c_request: int=%b expected 1", interrupt); end
        bus_write(3'd0, 16'h0002);
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL w1c_drop: int=%b expected 0", interrupt); end
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL w1c_cleared: got %h expected 0000", d); end
        pulse(8'h02);
        irq = 8'h02; tick(); tick();
        bus_if.address = BASE; bus_if.data_out = 16'h0002; bus_if.nwr = 1'b0; bus_if.mem_valid = 1'b1;
        tick();
        bus_if.mem_valid = 1'b0; bus_if.nwr = 1'b1; irq = 8'h00;
        tick();
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0002) begin failures++; $display("FAIL w1c_set_wins: got %h expected 0002", d); end
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL w1c_set_req: int=%b expected 1", interrupt); end
        clean();
    endtask

    task automatic test_bus_timing();
        logic [15:0] d;
        logic [15:0] en = 16'($urandom_range(1, 255));
        bus_write(3'd1, en);
        bus_if.address = BASE | 16'd1; bus_if.nwr = 1'b1; bus_if.mem_valid = 1'b1;
        #1;
        checks++; if (bus_if.mem_ready !== 1'b0) begin failures++; $display("FAIL bus_ready_c1: got %b expected 0", bus_if.mem_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus_if.mem_ready !== 1'b1 || bus_if.data_in !== en) begin
                failures++; $display("FAIL bus_hold_%0d: rdy=%b din=%h expected 1/%h", k, bus_if.mem_ready, bus_if.data_in, en);
            end
        end
        bus_if.mem_valid = 1'b0;
        tick();
        checks++; if (bus_if.mem_ready !== 1'b0 || bus_if.data_in !== 16'h0) begin
            failures++; $display("FAIL bus_release: rdy=%b din=%h expected 0/0000", bus_if.mem_ready, bus_if.data_in);
        end
        bus_write(3'd1, 16'h0000);
        pulse(8'h08);
        irq = 8'h08; tick();
        bus_if.address = BASE; bus_if.data_out = 16'h0008; bus_if.nwr = 1'b0; bus_if.mem_valid = 1'b1;
        repeat (3) tick();
        bus_if.mem_valid = 1'b0; bus_if.nwr = 1'b1; irq = 8'h00;
        tick();
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0008) begin failures++; $display("FAIL bus_w1c_once: got %h expected 0008", d); end
        bus_write(3'd6, 16'hFFFF);
        bus_read(3'd6, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL bus_off6: got %h expected 0000", d); end
        bus_if.address = 16'hFE01; bus_if.nwr = 1'b1; bus_if.mem_valid = 1'b1;
        tick();
        checks++; if (bus_if.mem_ready !== 1'b0) begin failures++; $display("FAIL bus_decode_miss: rdy=%b expected 0", bus_if.mem_ready); end
        bus_if.mem_valid = 1'b0;
        tick();
        clean();
    endtask

    task automatic test_spurious_eoi();
        logic [15:0] d;
        bit ok;
        bus_write(3'd1, 16'h0010);
        pulse(8'h10);
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL spur_request: int=%b expected 1", interrupt); end
        bus_if.address = BASE | 16'd1; bus_if.data_out = 16'h0000; bus_if.nwr = 1'b0; bus_if.mem_valid = 1'b1;
        tick();
        bus_if.mem_valid = 1'b0; bus_if.nwr = 1'b1; in_interrupt = 1'b1;
        tick();
        bus_read(3'd2, d);
        checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL spur_active: got %h expected FFFF", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0010) begin failures++; $display("FAIL spur_pending: got %h expected 0010", d); end
        bus_write(3'd3, 16'h0000);
        bus_write(3'd1, 16'h0010);
        tick();
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL eoi_hold_idle: int=%b expected 0", interrupt); end
        in_interrupt = 1'b0;
        tick();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL eoi_idle_req: int=%b expected 1", interrupt); end
        handler(1, d, ok);
        checks++; if (!ok || d !== 16'h0004) begin failures++; $display("FAIL eoi_service: ok=%0d active=%h expected 0004", ok, d); end
        clean();
    endtask

    task automatic test_reset_corners();
        logic [15:0] d;
        bit ok;
        bit seen = 1'b0;
        bus_if.address = BASE | 16'd1; bus_if.nwr = 1'b1; bus_if.mem_valid = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_if.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_async_ready: got %b expected 0", bus_if.mem_ready); end
        bus_if.mem_valid = 1'b0;
        in_interrupt = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus_write(3'd1, 16'h0001);
        pulse(8'h01);
        tick();
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rst_inint_hold: int=%b expected 0", interrupt); end
        in_interrupt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (interrupt === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL rst_inint_release: int=%b expected 1", interrupt); end
        handler(0, d, ok);
        checks++; if (!ok || d !== 16'h0000) begin failures++; $display("FAIL rst_inint_service: ok=%0d active=%h expected 0000", ok, d); end
        clean();
    endtask

    task automatic test_random();
        logic [15:0] d;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            logic [7:0] en = 8'($urandom_range(1, 255));
            logic [7:0] m  = 8'($urandom_range(1, 255));
            int q[$];
            for (int i = 0; i < 8; i++)
                if (en[i] && m[i]) q.push_back(i);
            bus_write(3'd1, 16'(en));
            pulse(m);
            while (q.size() > 0) begin
                int exp_id = q.pop_front();
                handler(int'($urandom_range(0, 3)), d, ok);
                checks++; if (!ok || d !== 16'(exp_id)) begin
                    failures++; $display("FAIL rand_order it=%0d: ok=%0d active=%h expected %h", it, ok, d, 16'(exp_id));
                end
            end
            repeat (3) tick();
            checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rand_idle it=%0d: int=%b expected 0", it, interrupt); end
            bus_read(3'd0, d);
            checks++; if (d !== 16'(m & ~en)) begin failures++; $display("FAIL rand_leftover it=%0d: got %h expected %h", it, d, 16'(m & ~en)); end
            clean();
        end
    endtask

    task automatic test_level();
        logic [15:0] d;
        bit ok;
`ifdef TINY16_INTC_LEVEL_EN
        bus_write(3'd4, 16'h0001);
        bus_write(3'd1, 16'h0001);
        irq = 8'h01;
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            handler(0, d, ok);
            checks++; if (!ok || d !== 16'h0000) begin failures++; $display("FAIL level_rerequest_%0d: ok=%0d active=%h expected 0000", k, ok, d); end
        end
        bus_write(3'd0, 16'h0001);
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0001) begin failures++; $display("FAIL level_w1c_ignored: got %h expected 0001", d); end
        irq = 8'h00;
        repeat (6) tick();
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL level_release: int=%b expected 0", interrupt); end
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL level_pending_low: got %h expected 0000", d); end
`else
        ok = 1'b1;
        bus_write(3'd4, 16'hFFFF);
        bus_read(3'd4, d);
        checks++; if (!ok || d !== 16'h0000) begin failures++; $display("FAIL level_absent: got %h expected 0000", d); end
`endif
        clean();
    endtask

    initial begin
        bus_if.address = 16'h0000;
        bus_if.data_out = 16'h0000;
        bus_if.nwr = 1'b1;
        bus_if.mem_valid = 1'b0;
        test_reset();
        test_priority();
        test_enable_late();
        test_w1c();
        test_bus_timing();
        test_spurious_eoi();
        test_reset_corners();
        test_random();
        test_level();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
